// File: rtl/rob_pkg.sv
// Shared types and widths for the ROB response path and the AR-side tag allocator.
package rob_pkg;

  localparam int R_ID_W     = 4;
  localparam int R_DATA_W   = 64;
  localparam int R_RESP_W   = 2;
  localparam int R_TAG_W    = 4;
  localparam int R_NUM_TAGS = 1 << R_TAG_W;

  localparam logic [R_RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [R_ID_W-1:0]   id;
    logic [R_DATA_W-1:0] data;
    logic [R_RESP_W-1:0] resp;
    logic                last;
    logic [R_TAG_W-1:0]  tagid;
  } r_beat_t;

  typedef struct packed {
    logic              valid;
    logic [R_ID_W-1:0] id;
  } tag_entry_t;

endpackage

// File: rtl/r_if.sv
// AXI R-channel bundle extended with the ROB tag.
interface r_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int TAG_WIDTH  = 4
);
  logic                  valid;
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [RESP_WIDTH-1:0] resp;
  logic                  last;
  logic [TAG_WIDTH-1:0]  tagid;
  logic                  ready;

  modport master (output valid, id, data, resp, last, tagid, input ready);
  modport slave  (input valid, id, data, resp, last, tagid, output ready);
endinterface

// File: rtl/r_fifo2.sv
// Two-entry FIFO of R beats; full throughput, registered output.
module r_fifo2
  import rob_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid_i,
  output logic    in_ready_o,
  input  r_beat_t in_beat_i,
  output logic    out_valid_o,
  input  logic    out_ready_i,
  output r_beat_t out_beat_o
);

  r_beat_t    mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  // Ready is held low during reset so nothing is accepted into a clearing buffer.
  assign in_ready_o  = (count_q != 2'd2) && !rst;
  assign out_valid_o = (count_q != 2'd0);
  assign out_beat_o  = mem_q[rd_ptr_q];

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_beat_i;
  end

endmodule

// File: rtl/r_id_restore.sv
// Restores the original AXI ID on tagged R beats and retires tags when a burst completes.
module r_id_restore
  import rob_pkg::*;
#(
  parameter int ID_WIDTH   = R_ID_W,
  parameter int DATA_WIDTH = R_DATA_W,
  parameter int RESP_WIDTH = R_RESP_W,
  parameter int TAG_WIDTH  = R_TAG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  input  logic [TAG_WIDTH-1:0] alloc_tag,
  input  logic [ID_WIDTH-1:0]  alloc_id,
  r_if.slave                   r_in,
  r_if.master                  r_out,
  output logic                 free_valid,
  output logic [TAG_WIDTH-1:0] free_tag,
  output logic                 err_unalloc
);

  localparam int NUM_TAGS = 2 ** TAG_WIDTH;

  logic [NUM_TAGS-1:0]   vld_q, vld_d;
  logic [ID_WIDTH-1:0]   id_q [NUM_TAGS];
  tag_entry_t            ent;
  logic [ID_WIDTH-1:0]   beat_id;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [RESP_WIDTH-1:0] beat_resp;
  r_beat_t               push_beat, head;
  logic                  push_rdy, pop_vld;
  logic                  accept, retire;
  logic                  free_valid_q;
  logic [TAG_WIDTH-1:0]  free_tag_q;
  logic                  err_q;
  logic                  unused_id;

  assign unused_id = ^r_in.id;

  // Lookup sees the pre-edge table; a same-cycle alloc is not bypassed.
  assign ent.valid = vld_q[r_in.tagid];
  assign ent.id    = id_q[r_in.tagid];

  assign beat_id   = ent.valid ? ent.id : '0;
  assign beat_resp = ent.valid ? r_in.resp : RESP_SLVERR;
  assign beat_data = r_in.data;
  assign push_beat = {beat_id, beat_data, beat_resp, r_in.last, r_in.tagid};

  r_fifo2 u_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (r_in.valid),
    .in_ready_o  (push_rdy),
    .in_beat_i   (push_beat),
    .out_valid_o (pop_vld),
    .out_ready_i (r_out.ready),
    .out_beat_o  (head)
  );

  assign r_in.ready  = push_rdy;
  assign r_out.valid = pop_vld;
  assign r_out.id    = head.id;
  assign r_out.data  = head.data;
  assign r_out.resp  = head.resp;
  assign r_out.last  = head.last;
  assign r_out.tagid = head.tagid;

  assign accept = r_in.valid && push_rdy;
  assign retire = pop_vld && r_out.ready && head.last;

  // Alloc is applied after retire so it wins on a same-tag collision.
  always_comb begin
    vld_d = vld_q;
    if (retire)      vld_d[head.tagid] = 1'b0;
    if (alloc_valid) vld_d[alloc_tag]  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q        <= '0;
      free_valid_q <= 1'b0;
      free_tag_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      vld_q        <= vld_d;
      free_valid_q <= retire;
      if (retire) free_tag_q <= head.tagid;
      err_q        <= accept && !ent.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_valid) id_q[alloc_tag] <= alloc_id;
  end

  assign free_valid  = free_valid_q;
  assign free_tag    = free_tag_q;
  assign err_unalloc = err_q;

endmodule

// File: tb/tb_r_id_restore.sv
// Scoreboard bench for r_id_restore: directed beats with hand-computed restored IDs.
module tb_r_id_restore;
  import rob_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alloc_valid;
  logic [3:0] alloc_tag;
  logic [3:0] alloc_id;
  logic       free_valid;
  logic [3:0] free_tag;
  logic       err_unalloc;

  r_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2), .TAG_WIDTH(4)) rin ();
  r_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2), .TAG_WIDTH(4)) rout ();

  r_id_restore dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_tag   (alloc_tag),
    .alloc_id    (alloc_id),
    .r_in        (rin),
    .r_out       (rout),
    .free_valid  (free_valid),
    .free_tag    (free_tag),
    .err_unalloc (err_unalloc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    r_beat_t b;
    int      acc;
    bit      lat;
  } exp_t;

  exp_t    q[$];
  int      fq[$];
  int      fcyc[$];
  int      total = 0;
  int      bad = 0;
  int      err_cnt = 0;
  bit      lat_mode = 1'b1;
  bit      held = 1'b0;
  r_beat_t snap, cur;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: beats, stall stability, free pulses, error pulses.
  always @(negedge clk) begin
    exp_t e;
    int   t, c;
    if (err_unalloc) err_cnt++;
    if (free_valid) begin
      if (fq.size() == 0 || fcyc.size() == 0) check("free_unexpected", free_valid, 1'b0);
      else begin
        t = fq.pop_front();
        c = fcyc.pop_front();
        check("free_tag", free_tag, t[3:0]);
        check("free_timing", cyc, c + 1);
      end
    end
    cur = {rout.id, rout.data, rout.resp, rout.last, rout.tagid};
    if (held && rout.valid) check("stall_hold", cur, snap);
    held = rout.valid && !rout.ready;
    snap = cur;
    if (rout.valid && rout.ready && !rst) begin
      if (q.size() == 0) check("beat_unexpected", rout.valid, 1'b0);
      else begin
        e = q.pop_front();
        check("beat", cur, e.b);
        if (e.lat) check("latency", cyc, e.acc + 1);
        if (cur.last) fcyc.push_back(cyc);
      end
    end
  end

  task automatic alloc(input logic [3:0] t, input logic [3:0] i);
    alloc_valid = 1'b1;
    alloc_tag   = t;
    alloc_id    = i;
    @(posedge clk);
    #1 alloc_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] tag, input logic [63:0] d, input logic l,
                      input logic [3:0] eid, input logic [1:0] eresp);
    int   n = 0;
    exp_t e;
    rin.valid = 1'b1;
    rin.id    = 4'h9;
    rin.tagid = tag;
    rin.data  = d;
    rin.resp  = 2'b00;
    rin.last  = l;
    @(negedge clk);
    while (!rin.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rin.ready) begin
      check("accept_timeout", rin.ready, 1'b1);
      @(posedge clk);
      #1 rin.valid = 1'b0;
      return;
    end
    e.b   = {eid, d, eresp, l, tag};
    e.acc = cyc;
    e.lat = lat_mode;
    q.push_back(e);
    if (l) fq.push_back(int'(tag));
    @(posedge clk);
    #1 rin.valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rin.valid   = 1'b0;
    rin.id      = '0;
    rin.tagid   = '0;
    rin.data    = '0;
    rin.resp    = '0;
    rin.last    = 1'b0;
    rout.ready  = 1'b1;
    alloc_valid = 1'b0;
    alloc_tag   = '0;
    alloc_id    = '0;

    #1 rst = 1'b1;
    #2;
    check("rst_rin_ready", rin.ready, 1'b0);
    check("rst_rout_valid", rout.valid, 1'b0);
    check("rst_free_valid", free_valid, 1'b0);
    check("rst_free_tag", free_tag, 4'h0);
    check("rst_err", err_unalloc, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rin_ready_after_rst", rin.ready, 1'b1);
    @(posedge clk);
    #1;

    // Basic 4-beat burst, tag 3 -> ID 0xA
    alloc(4'd3, 4'hA);
    for (int i = 1; i <= 4; i++) send(4'd3, 64'(i), (i == 4), 4'hA, 2'b00);
    drain();

    // Same burst with output stalled
    alloc(4'd3, 4'hA);
    lat_mode   = 1'b0;
    rout.ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(4'd3, 64'(16 + i), (i == 4), 4'hA, 2'b00);
      end
      begin
        repeat (3) @(negedge clk);
        check("stall_rin_ready", rin.ready, 1'b0);
        check("stall_rout_valid", rout.valid, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rout.ready = 1'b1;
      end
    join
    drain();
    lat_mode = 1'b1;

    // Unmapped tag 7
    e0 = err_cnt;
    send(4'd7, 64'hDEAD, 1'b1, 4'h0, RESP_SLVERR);
    drain();
    check("err_once_unmapped", err_cnt - e0, 1);

    // Retire and re-alloc of tag 5 on the same edge
    alloc(4'd5, 4'h7);
    lat_mode   = 1'b0;
    rout.ready = 1'b0;
    send(4'd5, 64'h55, 1'b1, 4'h7, 2'b00);
    alloc_valid = 1'b1;
    alloc_tag   = 4'd5;
    alloc_id    = 4'h2;
    rout.ready  = 1'b1;
    @(posedge clk);
    #1 alloc_valid = 1'b0;
    e0 = err_cnt;
    send(4'd5, 64'h56, 1'b1, 4'h2, 2'b00);
    drain();
    check("err_none_realloc", err_cnt - e0, 0);
    lat_mode = 1'b1;

    // Interleaved tags 1, 2, 1 at full rate
    alloc(4'd1, 4'h1);
    alloc(4'd2, 4'hF);
    send(4'd1, 64'h100, 1'b0, 4'h1, 2'b00);
    send(4'd2, 64'h200, 1'b1, 4'hF, 2'b00);
    send(4'd1, 64'h300, 1'b1, 4'h1, 2'b00);
    drain();

    // Reset with two beats buffered
    alloc(4'd9, 4'h3);
    lat_mode   = 1'b0;
    rout.ready = 1'b0;
    send(4'd9, 64'h900, 1'b0, 4'h3, 2'b00);
    send(4'd9, 64'h901, 1'b0, 4'h3, 2'b00);
    check("full_before_rst", rin.ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_rout_valid", rout.valid, 1'b0);
    check("rst_mid_rin_ready", rin.ready, 1'b0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b0;
    rout.ready = 1'b1;
    @(posedge clk);
    #1;
    e0 = err_cnt;
    send(4'd9, 64'h902, 1'b1, 4'h0, RESP_SLVERR);
    drain();
    check("err_after_rst", err_cnt - e0, 1);

    check("free_pending", fq.size(), 0);
    check("free_cyc_pending", fcyc.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
